// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational execute-stage ALU between two requesters
//   (port 0: main execute path, port 1: auxiliary unit). A round-robin
//   grant is made each cycle. The winner's operands and opcode drive the
//   ALU, and the result is captured into a one-entry response buffer. The
//   buffer uses valid/ready handshaking and tags each response with the
//   ID of the requester that issued it.
//
//   Optional feature macro: ALU_ARB_FLAGS_EN
//     defined   -> alu_blt/bgt/zero are captured with the result
//     undefined -> flag inputs are ignored and rsp_blt/bgt/zero read 0
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   reqN_valid/reqN_ready   per-port request handshake (N = 0, 1)
//   reqN_srca/srcb/op       per-port operands and ALU opcode
//   alu_srca/srcb/op        operands and opcode driven to the ALU
//   alu_result, alu_blt/bgt/zero   ALU result and compare flags
//   rsp_valid/rsp_ready     response handshake
//   rsp_id                  requester that issued the buffered result
//   rsp_result, rsp_blt/bgt/zero   registered result and flags
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic                     alu_blt,
  input  logic                     alu_bgt,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_result,
  output logic                     rsp_blt,
  output logic                     rsp_bgt,
  output logic                     rsp_zero
);

  typedef enum logic {EMPTY, FULL} buf_state_t;

  buf_state_t state;
  logic       last_grant;
  logic       can_accept;
  logic       grant0, grant1;
  logic       xfer0, xfer1, xfer;

  // last_grant == 1 means port 1 won the most recent transfer, so port 0
  // is preferred on the next contention (and vice versa).
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  // A full buffer can refill in the same cycle it drains. Reset blocks
  // every transfer so nothing is lost across the reset edge.
  assign can_accept = ~reset & ((state == EMPTY) | rsp_ready);

  assign req0_ready = grant0 & can_accept;
  assign req1_ready = grant1 & can_accept;

  assign xfer0 = req0_valid & req0_ready;
  assign xfer1 = req1_valid & req1_ready;
  assign xfer  = xfer0 | xfer1;

  always_comb begin
    alu_srca = '0;
    alu_srcb = '0;
    alu_op   = '0;
    if (xfer0) begin
      alu_srca = req0_srca;
      alu_srcb = req0_srcb;
      alu_op   = req0_op;
    end else if (xfer1) begin
      alu_srca = req1_srca;
      alu_srcb = req1_srcb;
      alu_op   = req1_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      state      <= FULL;
      rsp_valid  <= 1'b1;
      rsp_id     <= xfer1;
      rsp_result <= alu_result;
      last_grant <= xfer1;
    end else if ((state == FULL) && rsp_ready) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_blt  <= 1'b0;
      rsp_bgt  <= 1'b0;
      rsp_zero <= 1'b0;
    end else if (xfer) begin
      rsp_blt  <= alu_blt;
      rsp_bgt  <= alu_bgt;
      rsp_zero <= alu_zero;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = alu_blt ^ alu_bgt ^ alu_zero;
  assign rsp_blt  = 1'b0;
  assign rsp_bgt  = 1'b0;
  assign rsp_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;
`ifdef ALU_ARB_FLAGS_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [OW-1:0] req0_op, req1_op;
  logic [DW-1:0] alu_srca, alu_srcb, alu_result;
  logic [OW-1:0] alu_op;
  logic          alu_blt, alu_bgt, alu_zero;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0] rsp_result;
  logic          rsp_blt, rsp_bgt, rsp_zero;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_op(req1_op),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
    .alu_result(alu_result), .alu_blt(alu_blt), .alu_bgt(alu_bgt),
    .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_blt(rsp_blt), .rsp_bgt(rsp_bgt),
    .rsp_zero(rsp_zero)
  );

  // Combinational ALU standing in for the execute-stage unit
  always_comb begin
    alu_result = '0;
    alu_blt    = 1'b0;
    alu_bgt    = 1'b0;
    alu_zero   = 1'b0;
    case (alu_op)
      4'b0000: alu_result = alu_srca & alu_srcb;
      4'b0001: alu_result = alu_srca | alu_srcb;
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b0011: alu_result = alu_srca ^ alu_srcb;
      4'b0100: alu_result = alu_srca << alu_srcb[4:0];
      4'b0101: alu_result = {31'd0, alu_srca < alu_srcb};
      4'b0110: begin
        alu_result = alu_srca - alu_srcb;
        alu_blt    = $signed(alu_srca) < $signed(alu_srcb);
        alu_bgt    = $signed(alu_srca) > $signed(alu_srcb);
        alu_zero   = alu_srca == alu_srcb;
      end
      4'b0111: begin
        alu_result = alu_srca - alu_srcb;
        alu_blt    = alu_srca < alu_srcb;
        alu_bgt    = alu_srca > alu_srcb;
        alu_zero   = alu_srca == alu_srcb;
      end
      4'b1000: alu_result = alu_srca >> alu_srcb[4:0];
      4'b1010: alu_result = {31'd0, $signed(alu_srca) < $signed(alu_srcb)};
      4'b1100: alu_result = $unsigned($signed(alu_srca) >>> alu_srcb[4:0]);
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [OW-1:0] op);
    req0_valid = v; req0_srca = a; req0_srcb = b; req0_op = op;
  endtask

  task automatic set_req1(input logic v, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [OW-1:0] op);
    req1_valid = v; req1_srca = a; req1_srcb = b; req1_op = op;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b1;
    set_req0(1'b0, '0, '0, '0);
    set_req1(1'b0, '0, '0, '0);
    step();
    step();

    // Reset state; no transfer while reset is held
    set_req0(1'b1, 32'd5, 32'd7, 4'b0010);
    #1;
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_id", {31'd0, rsp_id}, 32'd0);
    check("rst_flags", {29'd0, rsp_blt, rsp_bgt, rsp_zero}, 32'd0);
    step();
    check("rst_noxfer", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    req0_valid = 1'b0;
    #1;
    check("idle_alu_op", {28'd0, alu_op}, 32'd0);
    check("idle_alu_srca", alu_srca, 32'd0);

    // Contention: alternates 0,1,0,1 starting with port 0
    set_req0(1'b1, 32'd10, 32'd3, 4'b0110);
    set_req1(1'b1, 32'hF0, 32'h0F, 4'b0011);
    #1;
    check("cont_ready0", {31'd0, req0_ready}, 32'd1);
    check("cont_ready1", {31'd0, req1_ready}, 32'd0);
    check("cont_alu_srca", alu_srca, 32'd10);
    for (int i = 0; i < 4; i++) begin
      step();
      check("cont_valid", {31'd0, rsp_valid}, 32'd1);
      check("cont_id", {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check("cont_result", rsp_result, (i % 2 == 0) ? 32'd7 : 32'hFF);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check("drain_valid", {31'd0, rsp_valid}, 32'd0);

    // Single requester on port 0: ADD 5 + 7
    set_req0(1'b1, 32'd5, 32'd7, 4'b0010);
    #1;
    check("add_ready0", {31'd0, req0_ready}, 32'd1);
    step();
    check("add_valid", {31'd0, rsp_valid}, 32'd1);
    check("add_id", {31'd0, rsp_id}, 32'd0);
    check("add_result", rsp_result, 32'd12);
    req0_valid = 1'b0;
    step();
    check("add_drain", {31'd0, rsp_valid}, 32'd0);

    // Backpressure: port 1 SRA held while the consumer stalls
    set_req1(1'b1, 32'h8000_0000, 32'd4, 4'b1100);
    rsp_ready = 1'b0;
    #1;
    check("bp_ready1", {31'd0, req1_ready}, 32'd1);
    step();
    check("bp_id", {31'd0, rsp_id}, 32'd1);
    check("bp_result", rsp_result, 32'hF800_0000);
    set_req0(1'b1, 32'd10, 32'd3, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_hold_ready0", {31'd0, req0_ready}, 32'd0);
      check("bp_hold_ready1", {31'd0, req1_ready}, 32'd0);
      step();
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_id", {31'd0, rsp_id}, 32'd1);
      check("bp_hold_result", rsp_result, 32'hF800_0000);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_rel_ready0", {31'd0, req0_ready}, 32'd1);
    check("bp_rel_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    check("bp_rel_id", {31'd0, rsp_id}, 32'd0);
    check("bp_rel_result", rsp_result, 32'd7);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // Compare flags
    set_req0(1'b1, 32'd3, 32'd5, 4'b0110);
    step();
    check("sub_result", rsp_result, 32'hFFFF_FFFE);
    check("sub_flags", {29'd0, rsp_blt, rsp_bgt, rsp_zero}, {29'd0, FE, 1'b0, 1'b0});
    set_req0(1'b1, 32'd4, 32'd4, 4'b0111);
    step();
    check("subu_result", rsp_result, 32'd0);
    check("subu_flags", {29'd0, rsp_blt, rsp_bgt, rsp_zero}, {29'd0, 1'b0, 1'b0, FE});

    // Unsupported opcode passes through and returns 0
    set_req0(1'b1, 32'd5, 32'd5, 4'b1111);
    step();
    check("unsup_result", rsp_result, 32'd0);
    check("unsup_flags", {29'd0, rsp_blt, rsp_bgt, rsp_zero}, 32'd0);

    // Drain and refill in the same cycle from port 1
    req0_valid = 1'b0;
    set_req1(1'b1, 32'd1, 32'd2, 4'b0001);
    #1;
    check("refill_ready1", {31'd0, req1_ready}, 32'd1);
    step();
    check("refill_valid", {31'd0, rsp_valid}, 32'd1);
    check("refill_id", {31'd0, rsp_id}, 32'd1);
    check("refill_result", rsp_result, 32'd3);

    // Leave port 0 as last winner, then reset while FULL with both valid
    req1_valid = 1'b0;
    set_req0(1'b1, 32'd10, 32'd3, 4'b0110);
    step();
    check("pre_rst_id", {31'd0, rsp_id}, 32'd0);
    set_req1(1'b1, 32'hF0, 32'h0F, 4'b0011);
    reset = 1'b1;
    #1;
    check("mrst_ready0", {31'd0, req0_ready}, 32'd0);
    check("mrst_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    check("mrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mrst_result", rsp_result, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
    check("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    check("post_rst_id", {31'd0, rsp_id}, 32'd0);
    check("post_rst_result", rsp_result, 32'd7);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single combinational ALU of the execute stage between two requesters (port 0: main execute path, port 1: auxiliary unit such as an address/compare helper). Arbitrates per cycle with round-robin fairness, drives the ALU operands and opcode, and captures the result into a one-entry registered response buffer with valid/ready backpressure and a requester ID tag. Sits between the requesters and the ALU; the ALU itself stays purely combinational.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle (grant and buffer free)
- req0_srca, req0_srcb / req1_srca, req1_srcb  in  DATA_WIDTH  operands
- req0_op / req1_op  in  OPCODE_LENGTH  ALU operation code (ALU encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SLTU, 0110 SUB, 0111 SUBU, 1000 SRL, 1010 SLT, 1100 SRA)
- alu_srca, alu_srcb  out  DATA_WIDTH  operands to ALU
- alu_op  out  OPCODE_LENGTH  opcode to ALU
- alu_result  in  DATA_WIDTH  ALU result
- alu_blt, alu_bgt, alu_zero  in  1  ALU compare flags (SUB/SUBU only)
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer takes the response this cycle
- rsp_id  out  1  requester that issued the result (0 or 1)
- rsp_result  out  DATA_WIDTH  registered ALU result
- rsp_blt, rsp_bgt, rsp_zero  out  1  registered compare flags

## Operation
- Buffer state machine: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- can_accept = EMPTY, or FULL with rsp_ready=1 (drain and refill same cycle).
- Grant: only one requester valid -> that one; both valid -> the one not equal to last_grant; neither -> no grant.
- reqN_ready = grantN & can_accept; combinational from reqN_valid. Requesters must not make valid depend on ready.
- Transfer on port N = reqN_valid & reqN_ready. On transfer: ALU driven with port N's srca/srcb/op the same cycle; next edge loads rsp_result=alu_result, rsp_id=N, flags, rsp_valid=1, last_grant=N.
- No transfer: alu_srca=alu_srcb=0, alu_op=4'b0000; last_grant unchanged.
- FULL & rsp_ready & no new transfer -> EMPTY. FULL & ~rsp_ready -> hold all rsp_* stable, both readys 0.
- last_grant updates only on an actual transfer; a grant blocked by a full buffer does not rotate priority.
- Opcode not decoded here; unsupported codes pass through and return the ALU's default result (0).

## Timing
- Reset (synchronous): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_blt/bgt/zero=0, last_grant=1 (port 0 wins first contention); state EMPTY.
- Reset asserted mid-operation: any buffered response dropped at that edge, no transfer that cycle (readys forced 0 while reset=1).
- Latency: request accepted in cycle T -> rsp_valid=1 with result in cycle T+1.
- Throughput: one op per cycle with rsp_ready held 1; back-to-back contention alternates 0,1,0,1.
- Simultaneous drain and accept: old response leaves, new one loaded at the same edge; rsp_valid stays 1.
- Response fields change only on a load edge or reset.

## Configuration
- ALU_ARB_FLAGS_EN defined: alu_blt/bgt/zero captured with the result and presented on rsp_blt/bgt/zero.
- Not defined: flag inputs ignored, no flag registers; rsp_blt/bgt/zero constant 0.

## Test plan
- Port 0 only: ADD 5 + 7 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=12.
- Both valid every cycle, port 0 SUB 10-3, port 1 XOR 0xF0^0x0F, rsp_ready=1 -> responses id 0 (7), 1 (0xFF), 0, 1, ... alternating; first grant to port 0 after reset.
- Backpressure: load port 1 SRA 0x80000000>>>4, rsp_ready=0 for 3 cycles with both requests valid -> rsp holds 0xF8000000 id 1, both readys 0; rsp_ready=1 -> next grant to port 0.
- Flags (ALU_ARB_FLAGS_EN): SUB 3-5 -> rsp_result=0xFFFFFFFE, rsp_blt=1, rsp_bgt=0, rsp_zero=0; SUBU 4-4 -> zero=1. Without macro -> all flags 0.
- Reset while FULL with both requests valid -> next cycle rsp_valid=0, rsp_result=0, no transfer during reset; first post-reset contention granted to port 0.
- Drain-and-refill: FULL with rsp_ready=1 and port 1 OR 0x1|0x2 -> rsp_valid stays 1, next result 3 id 1.
